serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
Bit-serial subtractor computing diff = a − b one bit per clock, LSB first. It uses a single registered borrow, so each step is a half-subtractor pair (the inverse of the half-adder cell).
- Sits in the ALU path as the area-cheap alternative to the parallel adder/subtractor.
- Controlled by a start/busy/done handshake.
- Results are held stable until the next accepted start.

Parameters:
WIDTH, 8, operand and result width in bits (≥2).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, captured on the accepting edge
b  input  WIDTH  subtrahend, captured on the accepting edge
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when results become valid
diff  output  WIDTH  a − b modulo 2^WIDTH
borrow  output  1  1 iff a < b (unsigned)
overflow  output  1  signed overflow of a − b (two's complement)
zero  output  1  1 iff diff == 0

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, diff=0, borrow=0, overflow=0, zero=0, internal shift registers and bit counter cleared. Reset is effective immediately regardless of clk.
- Reset mid-operation aborts the subtraction. After rst deasserts, the block sits in IDLE with all outputs zero; no done pulse is produced.
- States:
  - IDLE: busy=0. On an edge with start=1: latch a→A_sh and b→B_sh, clear borrow register, count=0, go to RUN.
  - RUN: busy=1. Each edge processes bit 0 of the shift registers:
    - d = A0 ^ B0 ^ br
    - br_next = (~A0 & B0) | (~(A0 ^ B0) & br)
    - Shift A_sh and B_sh right by 1; shift d into the MSB of the result register; count++.
    - On the edge where count reaches WIDTH−1 (the WIDTH-th RUN edge), go to DONE.
  - DONE: exactly one cycle. done=1, busy=0. The next edge returns to IDLE unconditionally; start is ignored in DONE.
- Output timing:
  - diff, borrow, overflow and zero are registered. They update only on the edge entering DONE and hold until the edge entering DONE of the next operation.
  - Until then they keep their previous values; they do not change during RUN.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH. Total occupancy is WIDTH+2 cycles including the DONE cycle. The next start can be accepted at edge k+WIDTH+2.
- Flag definitions:
  - borrow = final br.
  - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operand MSBs.
  - zero = (diff == 0).
- start while busy or in DONE: ignored, with no effect on the in-flight operation. a and b changing during RUN have no effect.
- start held high continuously: a new operation begins on the first IDLE edge after each DONE.
- Edge cases: a == b → diff=0, borrow=0, zero=1. b=0 → diff=a, borrow=0.

Test Plan:
1. Reset then a=8'h05, b=8'h03, start one cycle → busy for 8 cycles, done pulse at cycle 9 after accept, diff=8'h02, borrow=0, overflow=0, zero=0.
2. a=8'h03, b=8'h05 → diff=8'hFE, borrow=1, overflow=0, zero=0; a=8'h80, b=8'h01 → diff=8'h7F, borrow=0, overflow=1.
3. a=8'hA5, b=8'hA5 → diff=8'h00, zero=1, borrow=0. Then a=8'h00, b=8'hFF → diff=8'h01, borrow=1. Check flags from the previous op hold unchanged during RUN.
4. Pulse start again at RUN cycle 3 with different a/b, and change a/b mid-run → ignored; result matches the first operands; exactly one done pulse.
5. Assert rst asynchronously (between edges) at RUN cycle 4 → busy/outputs go 0 immediately; no done; after release, a fresh op a=8'h10, b=8'h01 gives diff=8'h0F.
6. start held high across three ops → done pulses spaced exactly WIDTH+2 cycles apart. Randomised a/b (≥200 vectors) are checked against the parallel reference a−b, {borrow, diff} = {1'b0,a} − {1'b0,b}.

Source files
------------

// File: rtl/serial_sub_if.sv
// serial_sub_if: start/busy/done handshake and operand/result bus
// for the bit-serial subtractor.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow, zero
    );
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b, LSB first, one registered borrow.
// Results and flags are registered and held until the next op completes.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    serial_sub_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             am_q, am_d;
    logic             bm_q, bm_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             d_bit;
    logic             br_nx;

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            am_q     <= 1'b0;
            bm_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            am_q     <= am_d;
            bm_q     <= bm_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Next state: accept in IDLE, one subtract bit per RUN edge, one DONE cycle.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        am_d     = am_q;
        bm_d     = bm_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        d_bit    = a_q[0] ^ b_q[0] ^ br_q;
        br_nx    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    am_d    = bus.a[WIDTH-1];
                    bm_d    = bus.b[WIDTH-1];
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = br_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    diff_d   = res_d;
                    borrow_d = br_nx;
                    ovf_d    = (am_q != bm_q) && (res_d[WIDTH-1] != am_q);
                    zero_d   = (res_d == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: table vectors, corner sequences and random ops
// checked against a plain-arithmetic reference.
module tb_serial_sub;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: unsigned and signed arithmetic on whole operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic br,
                         output logic ov, output logic z);
        logic [W:0] wide;
        int         sd;
        wide = {1'b0, a} - {1'b0, b};
        d    = wide[W-1:0];
        br   = wide[W];
        sd   = int'($signed(a)) - int'($signed(b));
        ov   = (sd > 127) || (sd < -128);
        z    = (d == 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] d, output logic br,
                          output logic ov, output logic z,
                          output int busy_n);
        logic [W-1:0] hd;
        logic         hb;
        logic         hz;
        bit           got;
        hd = bus.diff;
        hb = bus.borrow;
        hz = bus.zero;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_n = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.done) begin
                got = 1;
            end else begin
                if (bus.busy) busy_n++;
                chk("hold_diff", bus.diff, hd);
                chk("hold_borrow", bus.borrow, hb);
                chk("hold_zero", bus.zero, hz);
                @(negedge clk);
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        chk("busy_in_done", bus.busy, 0);
        d  = bus.diff;
        br = bus.borrow;
        ov = bus.overflow;
        z  = bus.zero;
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        logic [W-1:0] d, ra, rb, md;
        logic         br, ov, z, mbr, mov, mz;
        int           bn, dn, n;
        int           t [3];

        checks = 0;
        errors = 0;
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_flags", {bus.borrow, bus.overflow, bus.zero}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, d, br, ov, z, bn);
            chk($sformatf("vec%0d_diff", i), d, vecs[i].diff);
            chk($sformatf("vec%0d_borrow", i), br, vecs[i].borrow);
            chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
            chk($sformatf("vec%0d_zero", i), z, vecs[i].zero);
            chk($sformatf("vec%0d_busy_cycles", i), bn, W);
        end

        // start re-pulsed and operands changed mid-run are ignored
        @(negedge clk);
        bus.a = 8'h5A;
        bus.b = 8'h33;
        bus.start = 1'b1;
        @(negedge clk);
        dn = 0;
        d = '0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) begin
                dn++;
                d = bus.diff;
            end
            bus.start = (i == 2);
            bus.a = (i == 2) ? 8'hFF : W'($urandom);
            bus.b = (i == 2) ? 8'h01 : W'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("ignore_start_done_count", dn, 1);
        chk("ignore_start_diff", d, 8'h27);

        // asynchronous reset between edges during RUN
        @(negedge clk);
        bus.a = 8'h44;
        bus.b = 8'h11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_diff", bus.diff, 0);
        chk("arst_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) dn++;
            @(negedge clk);
        end
        chk("arst_no_activity", dn, 0);
        run_op(8'h10, 8'h01, d, br, ov, z, bn);
        chk("after_rst_diff", d, 8'h0F);
        chk("after_rst_borrow", br, 0);

        // start held high: done pulses WIDTH+2 apart
        @(negedge clk);
        bus.a = 8'hC3;
        bus.b = 8'h4E;
        bus.start = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (bus.done) begin
                t[n] = cyc;
                n++;
                chk("held_diff", bus.diff, 8'h75);
                if (n == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("held_done_count", n, 3);
        if (n == 3) begin
            chk("held_gap1", t[1] - t[0], W + 2);
            chk("held_gap2", t[2] - t[1], W + 2);
        end
        repeat (2) @(negedge clk);
        chk("held_idle", bus.busy, 0);

        // random operands vs reference
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = (i % 16 == 0) ? ra : W'($urandom);
            model(ra, rb, md, mbr, mov, mz);
            run_op(ra, rb, d, br, ov, z, bn);
            chk($sformatf("rnd%0d_res %h-%h", i, ra, rb),
                {d, br, ov, z}, {md, mbr, mov, mz});
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
